lcd_text_driver: RTL and testbench

- Drives an HD44780-compatible 16x2 character LCD in 4-bit mode from a 256-bit (32-character) ASCII buffer.
- Performs the power-up initialisation, then writes line 1 and line 2.
- A one-cycle refresh request (`cls`) re-latches the buffer and redraws the panel.
- Sits at chip top between the debug/status string builder and the LCD pins.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_nibble_writer.sv | 76 +++++++
 rtl/lcd_text_driver.sv | 168 ++++++++++++++++
 tb/tb_lcd_text_driver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared command codes, FSM encodings and the time-to-cycles helper for the
// HD44780 4-bit text driver.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_4BIT_2L = 8'h28;
    localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_LINE1        = 8'h80;
    localparam logic [7:0] CMD_LINE2        = 8'hC0;

    localparam int unsigned UNIT_NS = 1;
    localparam int unsigned UNIT_US = 1_000;
    localparam int unsigned UNIT_MS = 1_000_000;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT,
        ST_CLEAR,
        ST_LATCH,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2,
        ST_IDLE
    } lcd_state_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        WR_WAIT
    } wr_state_t;

    // amount * unit_ns nanoseconds, rounded up to whole clock cycles
    function automatic int unsigned to_cycles(input int unsigned amount,
                                              input int unsigned unit_ns,
                                              input int unsigned clk_hz);
        longint unsigned total_ns;
        longint unsigned cycles;
        total_ns = 64'(amount) * 64'(unit_ns);
        cycles   = (total_ns * 64'(clk_hz) + 64'd999_999_999) / 64'd1_000_000_000;
        return cycles[31:0];
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Emits one nibble on the LCD bus: 2-cycle setup, E pulse, 2-cycle hold,
// then the inter-nibble gap plus a caller-supplied extra wait before done.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned E_CYC   = 12,
    parameter int unsigned GAP_CYC = 50,
    parameter int unsigned W       = 20
) (
    input  logic         CCLK,
    input  logic         rst_n,
    input  logic         start,
    input  logic         rs,
    input  logic [3:0]   nib,
    input  logic [W-1:0] wait_cycles,
    output logic         done,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic [3:0]   lcd_dat
);

    localparam int unsigned SETUP_CYC = 2;
    localparam int unsigned HOLD_CYC  = 2;

    wr_state_t    state, state_nx;
    logic [W-1:0] cnt, cnt_nx, wait_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - W'(1) : cnt;
        case (state)
            WR_IDLE: if (start) begin
                state_nx = WR_SETUP;
                cnt_nx   = W'(SETUP_CYC - 1);
            end
            WR_SETUP: if (cnt == '0) begin
                state_nx = WR_PULSE;
                cnt_nx   = W'(E_CYC - 1);
            end
            WR_PULSE: if (cnt == '0) begin
                state_nx = WR_HOLD;
                cnt_nx   = W'(HOLD_CYC - 1);
            end
            WR_HOLD: if (cnt == '0) begin
                state_nx = WR_WAIT;
                cnt_nx   = W'(GAP_CYC) + wait_q - W'(1);
            end
            WR_WAIT: if (cnt == '0) state_nx = WR_IDLE;
            default: state_nx = WR_IDLE;
        endcase
    end

    // rs/dat stay driven after the transfer so they are stable through hold
    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WR_IDLE;
            cnt     <= '0;
            wait_q  <= '0;
            done    <= 1'b0;
            lcd_e   <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_dat <= 4'h0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= (state == WR_WAIT) && (cnt == '0);
            lcd_e <= (state_nx == WR_PULSE);
            if (state == WR_IDLE && start) begin
                lcd_rs  <= rs;
                lcd_dat <= nib;
                wait_q  <= wait_cycles;
            end
        end
    end

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 driver in 4-bit mode: power-up init, then draws a 32-char buffer.
// LCD_CLS_CLEAR_EN: when defined, each cls redraw starts with a Clear Display.
//   state | meaning
//   PWRUP | wait for panel power-up after reset
//   INIT  | 3,3,3,2 nibbles then 0x28 0x06 0x0C 0x01
//   CLEAR | clear before a requested redraw (LCD_CLS_CLEAR_EN only)
//   LATCH | snapshot strdata, drop pending request
//   ADDR1 | set DDRAM address 0x80
//   LINE1 | 16 data bytes of line 1
//   ADDR2 | set DDRAM address 0xC0
//   LINE2 | 16 data bytes of line 2
//   IDLE  | wait for cls or pending request
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned E_PULSE_NS  = 240,
    parameter int unsigned NIB_GAP_NS  = 1000,
    parameter int unsigned CMD_WAIT_US = 40,
    parameter int unsigned CLR_WAIT_US = 1640,
    parameter int unsigned PWRUP_MS    = 15
) (
    input  logic         CCLK,
    input  logic         rst_n,
    input  logic         cls,
    input  logic [255:0] strdata,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [3:0]   lcd_dat
);

    localparam int unsigned C_E     = to_cycles(E_PULSE_NS, UNIT_NS, CLK_HZ);
    localparam int unsigned C_GAP   = to_cycles(NIB_GAP_NS, UNIT_NS, CLK_HZ);
    localparam int unsigned C_CMD   = to_cycles(CMD_WAIT_US, UNIT_US, CLK_HZ);
    localparam int unsigned C_CLR   = to_cycles(CLR_WAIT_US, UNIT_US, CLK_HZ);
    localparam int unsigned C_PWRUP = to_cycles(PWRUP_MS, UNIT_MS, CLK_HZ);
    localparam int unsigned C_INIT0 = to_cycles(4100, UNIT_US, CLK_HZ);
    localparam int unsigned C_INIT1 = to_cycles(100, UNIT_US, CLK_HZ);
    localparam int unsigned C_BIG   = (C_CLR > C_INIT0) ? C_CLR : C_INIT0;
    localparam int unsigned C_MAX   = (C_PWRUP > C_BIG + C_GAP) ? C_PWRUP : C_BIG + C_GAP;
    localparam int unsigned W       = $clog2(C_MAX + 1);

    lcd_state_t   state, state_nx;
    logic [4:0]   step;
    logic         busy, pending, sending, start, done;
    logic         byte_last, line_last, use_byte, cur_rs;
    logic [7:0]   cur_byte, line_char;
    logic [3:0]   raw_nib, nib;
    logic [W-1:0] byte_wait, raw_wait, wait_cycles, pwr_cnt;
    logic [255:0] text_q;

    assign lcd_rw    = 1'b0;
    assign start     = sending && !busy;
    assign byte_last = done && (step == 5'd1);
    assign line_last = done && (step == 5'd31);
    // step[4:1] is the column; shift puts that column's byte in the low 8 bits
    assign line_char = 8'(text_q >> {state != ST_LINE2, ~step[4:1], 3'b000});

    always_comb begin
        state_nx  = state;
        sending   = 1'b0;
        cur_rs    = 1'b0;
        cur_byte  = 8'h00;
        byte_wait = W'(C_CMD);
        use_byte  = 1'b1;
        raw_nib   = 4'h0;
        raw_wait  = '0;
        case (state)
            ST_PWRUP: if (pwr_cnt == '0) state_nx = ST_INIT;
            ST_INIT: begin
                sending = 1'b1;
                case (step)
                    5'd0: begin use_byte = 1'b0; raw_nib = 4'h3; raw_wait = W'(C_INIT0); end
                    5'd1: begin use_byte = 1'b0; raw_nib = 4'h3; raw_wait = W'(C_INIT1); end
                    5'd2: begin use_byte = 1'b0; raw_nib = 4'h3; raw_wait = W'(C_CMD);   end
                    5'd3: begin use_byte = 1'b0; raw_nib = 4'h2; raw_wait = W'(C_CMD);   end
                    5'd4, 5'd5: cur_byte = CMD_FUNC_4BIT_2L;
                    5'd6, 5'd7: cur_byte = CMD_ENTRY_INC;
                    5'd8, 5'd9: cur_byte = CMD_DISP_ON;
                    default: begin cur_byte = CMD_CLEAR; byte_wait = W'(C_CLR); end
                endcase
                if (done && step == 5'd11) state_nx = ST_LATCH;
            end
            ST_CLEAR: begin
                sending   = 1'b1;
                cur_byte  = CMD_CLEAR;
                byte_wait = W'(C_CLR);
                if (byte_last) state_nx = ST_LATCH;
            end
            ST_LATCH: state_nx = ST_ADDR1;
            ST_ADDR1: begin
                sending  = 1'b1;
                cur_byte = CMD_LINE1;
                if (byte_last) state_nx = ST_LINE1;
            end
            ST_LINE1: begin
                sending  = 1'b1;
                cur_rs   = 1'b1;
                cur_byte = line_char;
                if (line_last) state_nx = ST_ADDR2;
            end
            ST_ADDR2: begin
                sending  = 1'b1;
                cur_byte = CMD_LINE2;
                if (byte_last) state_nx = ST_LINE2;
            end
            ST_LINE2: begin
                sending  = 1'b1;
                cur_rs   = 1'b1;
                cur_byte = line_char;
                if (line_last) state_nx = ST_IDLE;
            end
            ST_IDLE: if (cls || pending) begin
`ifdef LCD_CLS_CLEAR_EN
                state_nx = ST_CLEAR;
`else
                state_nx = ST_LATCH;
`endif
            end
            default: state_nx = ST_PWRUP;
        endcase
        nib         = use_byte ? (step[0] ? cur_byte[3:0] : cur_byte[7:4]) : raw_nib;
        wait_cycles = use_byte ? (step[0] ? byte_wait : '0) : raw_wait;
    end

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_PWRUP;
            step    <= '0;
            busy    <= 1'b0;
            pending <= 1'b0;
            text_q  <= '0;
            pwr_cnt <= W'(C_PWRUP - 1);
        end else begin
            state <= state_nx;
            if (state_nx != state) step <= '0;
            else if (done)         step <= step + 5'd1;
            if (done)       busy <= 1'b0;
            else if (start) busy <= 1'b1;
            if (state == ST_PWRUP && pwr_cnt != '0) pwr_cnt <= pwr_cnt - W'(1);
            if (state == ST_LATCH) begin
                text_q  <= strdata;
                pending <= 1'b0;
            end else if (cls && state != ST_IDLE) begin
                pending <= 1'b1;
            end
        end
    end

    lcd_nibble_writer #(
        .E_CYC   (C_E),
        .GAP_CYC (C_GAP),
        .W       (W)
    ) u_writer (
        .CCLK        (CCLK),
        .rst_n       (rst_n),
        .start       (start),
        .rs          (cur_rs),
        .nib         (nib),
        .wait_cycles (wait_cycles),
        .done        (done),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_dat     (lcd_dat)
    );

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench for lcd_text_driver at 1 MHz: expected nibble stream and
// minimum spacing are queued from the protocol rules, a monitor checks the pins.
module tb_lcd_text_driver;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int PWRUP_CYC = 15000;
    localparam int INIT0_CYC = 4100;
    localparam int INIT1_CYC = 100;
    localparam int CMD_CYC   = 40;
    localparam int CLR_CYC   = 1640;
    localparam int GAP_CYC   = 1;
`ifdef LCD_CLS_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic         CCLK = 1'b0;
    logic         rst_n;
    logic         cls;
    logic [255:0] strdata;
    logic         lcd_rs, lcd_rw, lcd_e;
    logic [3:0]   lcd_dat;

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         min_gap;
        bit         from_rel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel_cycle = 0;
    int   prev_wait = 0;
    bit   first_pending = 1'b0;

    lcd_text_driver #(.CLK_HZ(CLK_HZ)) dut (
        .CCLK    (CCLK),
        .rst_n   (rst_n),
        .cls     (cls),
        .strdata (strdata),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_dat (lcd_dat)
    );

    always #500 CCLK = ~CCLK;
    always @(posedge CCLK) cyc <= cyc + 1;

    // reference model: spacing from previous E fall = hold 2 + gap + wait + setup 2
    task automatic push_nib(input logic rs, input logic [3:0] n, input int w);
        exp_t e;
        e.rs       = rs;
        e.nib      = n;
        e.from_rel = first_pending;
        e.min_gap  = first_pending ? PWRUP_CYC : 4 + GAP_CYC + prev_wait;
        first_pending = 1'b0;
        prev_wait  = w;
        exp_q.push_back(e);
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b, input int w);
        push_nib(rs, b[7:4], 0);
        push_nib(rs, b[3:0], w);
    endtask

    task automatic push_init();
        first_pending = 1'b1;
        push_nib(1'b0, 4'h3, INIT0_CYC);
        push_nib(1'b0, 4'h3, INIT1_CYC);
        push_nib(1'b0, 4'h3, CMD_CYC);
        push_nib(1'b0, 4'h2, CMD_CYC);
        push_byte(1'b0, 8'h28, CMD_CYC);
        push_byte(1'b0, 8'h06, CMD_CYC);
        push_byte(1'b0, 8'h0C, CMD_CYC);
        push_byte(1'b0, 8'h01, CLR_CYC);
    endtask

    task automatic push_draw(input logic [255:0] text, input bit with_clear);
        if (with_clear) push_byte(1'b0, 8'h01, CLR_CYC);
        push_byte(1'b0, 8'h80, CMD_CYC);
        for (int c = 0; c < 16; c++) push_byte(1'b1, text[255 - 8*c -: 8], CMD_CYC);
        push_byte(1'b0, 8'hC0, CMD_CYC);
        for (int c = 0; c < 16; c++) push_byte(1'b1, text[127 - 8*c -: 8], CMD_CYC);
    endtask

    function automatic logic [255:0] rand_text();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t;
    endfunction

    // monitor
    logic       prev_e = 1'b0;
    logic       h_rs [2];
    logic [3:0] h_dat [2];
    logic       hold_rs;
    logic [3:0] hold_dat;
    int         post_left = 0;
    int         last_fall = 0;
    int         mon_gap;
    exp_t       mon_e;

    always @(negedge CCLK) begin
        if (!rst_n) begin
            prev_e    = 1'b0;
            post_left = 0;
        end else begin
            if (lcd_e && !prev_e) begin
                checks++;
                if (lcd_rs !== h_rs[0] || lcd_rs !== h_rs[1] ||
                    lcd_dat !== h_dat[0] || lcd_dat !== h_dat[1]) begin
                    errors++;
                    $display("FAIL setup: rs %b%b dat %h%h before rise, required steady rs=%b dat=%h",
                             h_rs[1], h_rs[0], h_dat[1], h_dat[0], lcd_rs, lcd_dat);
                end
                checks++;
                if (lcd_rw !== 1'b0) begin
                    errors++;
                    $display("FAIL rw: got %b, required 0", lcd_rw);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_nibble: got rs=%b dat=%h at cycle %0d, required no E activity",
                             lcd_rs, lcd_dat, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (lcd_rs !== mon_e.rs || lcd_dat !== mon_e.nib) begin
                        errors++;
                        $display("FAIL nibble: got rs=%b dat=%h, required rs=%b dat=%h (cycle %0d)",
                                 lcd_rs, lcd_dat, mon_e.rs, mon_e.nib, cyc);
                    end
                    mon_gap = mon_e.from_rel ? cyc - rel_cycle : cyc - last_fall;
                    checks++;
                    if (mon_gap < mon_e.min_gap) begin
                        errors++;
                        $display("FAIL spacing: got %0d cycles before E rise, required >= %0d",
                                 mon_gap, mon_e.min_gap);
                    end
                end
                hold_rs  = lcd_rs;
                hold_dat = lcd_dat;
            end
            if (!lcd_e && prev_e) begin
                last_fall = cyc;
                post_left = 3;
            end
            if (post_left > 0) begin
                checks++;
                if (lcd_rs !== hold_rs || lcd_dat !== hold_dat) begin
                    errors++;
                    $display("FAIL hold: got rs=%b dat=%h after fall, required rs=%b dat=%h",
                             lcd_rs, lcd_dat, hold_rs, hold_dat);
                end
                post_left--;
            end
            prev_e = lcd_e;
        end
        h_rs[1]  = h_rs[0];
        h_rs[0]  = lcd_rs;
        h_dat[1] = h_dat[0];
        h_dat[0] = lcd_dat;
    end

    // stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge CCLK);
        #1;
    endtask

    task automatic pulse_cls();
        cls = 1'b1;
        tick(1);
        cls = 1'b0;
    endtask

    task automatic check_pins(input string name);
        checks++;
        if (lcd_rs !== 1'b0 || lcd_rw !== 1'b0 || lcd_e !== 1'b0 || lcd_dat !== 4'h0) begin
            errors++;
            $display("FAIL %s: got rs=%b rw=%b e=%b dat=%h, required all 0",
                     name, lcd_rs, lcd_rw, lcd_e, lcd_dat);
        end
    endtask

    task automatic wait_size(input int limit, input int budget, input string name);
        int n = 0;
        while (exp_q.size() > limit && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() > limit) begin
            errors++;
            $display("FAIL %s: got %0d nibbles outstanding after %0d cycles, required <= %0d",
                     name, exp_q.size(), budget, limit);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        cls     = 1'b0;
        strdata = "01234567 00 0123f01d01e01m01w01 ";
        tick(3);
        check_pins("reset_pins");

        push_init();
        push_draw(strdata, 1'b0);
        rst_n     = 1'b1;
        rel_cycle = cyc;
        tick(100);
        pulse_cls();
        wait_size(0, 60000, "init_draw");
        tick(1000);

        strdata[255:248] = "A";
        push_draw(strdata, CLR_EN);
        pulse_cls();
        wait_size(0, 6000, "cls_draw");
        tick(500);

        strdata = rand_text();
        push_draw(strdata, CLR_EN);
        pulse_cls();
        wait_size(56, 6000, "reach_line1");
        for (int k = 0; k < 3; k++) begin
            strdata = rand_text();
            pulse_cls();
            tick(40);
        end
        push_draw(strdata, CLR_EN);
        wait_size(0, 12000, "extra_draw");
        tick(1000);

        strdata = rand_text();
        push_draw(strdata, CLR_EN);
        pulse_cls();
        wait_size(20, 6000, "reach_line2");
        rst_n = 1'b0;
        #1;
        check_pins("async_reset");
        exp_q.delete();
        strdata = rand_text();
        tick(10);
        check_pins("held_reset");
        push_init();
        push_draw(strdata, 1'b0);
        rst_n     = 1'b1;
        rel_cycle = cyc;
        wait_size(0, 40000, "reinit_draw");
        tick(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
